// File: rtl/div_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// div_ctrl: one-bit-per-cycle restoring DIV/DIVU sequencer for EX. Rev 1.0
// ------------------------------------------------------------------
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_opdata1,
  input  logic [31:0] div_opdata2,
  input  logic        div_annul,
  output logic [63:0] div_result,
  output logic        div_ready,
  output logic        stallreq_for_div
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_neg_quo;
  logic        r_neg_rem;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic        w_stall;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [31:0] w_diff;
  logic        w_borrow;
  logic [64:0] w_work_step;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic        w_last;

  assign w_accept = div_start & ~div_annul;
  assign w_mag1   = (div_signed & div_opdata1[31]) ? (~div_opdata1 + 32'd1) : div_opdata1;
  assign w_mag2   = (div_signed & div_opdata2[31]) ? (~div_opdata2 + 32'd1) : div_opdata2;

  // The partial remainder spans working[64:32]; bit 64 set means it already exceeds any divisor.
  assign w_diff      = r_work[63:32] - r_divisor;
  assign w_borrow    = ~r_work[64] & (r_work[63:32] < r_divisor);
  assign w_work_step = w_borrow ? {r_work[63:0], 1'b0} : {w_diff, r_work[31:0], 1'b1};
  assign w_quo       = {r_work[30:0], ~w_borrow};
  assign w_rem       = w_borrow ? r_work[63:32] : w_diff;
  assign w_quo_fix   = r_neg_quo ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fix   = r_neg_rem ? (~w_rem + 32'd1) : w_rem;
  assign w_last      = (r_cnt == 5'd31);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stall     = 1'b1;
          w_state_nxt = (div_opdata2 == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        if (div_annul) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall     = 1'b1;
          w_state_nxt = S_END;
        end
      end
      S_ON: begin
        if (div_annul) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (w_last) begin
            w_state_nxt = S_END;
          end
        end
      end
      S_END: begin
        if (!div_start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 5'd0;
      r_work    <= 65'd0;
      r_divisor <= 32'd0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (div_opdata2 != 32'd0)) begin
            // Seeded one bit left so the first step already compares dividend bit 31.
            r_work    <= {32'd0, w_mag1, 1'b0};
            r_divisor <= w_mag2;
            r_neg_quo <= div_signed & (div_opdata1[31] ^ div_opdata2[31]);
            r_neg_rem <= div_signed & div_opdata1[31];
            r_cnt     <= 5'd0;
          end
        end
        S_DIVZERO: begin
          if (!div_annul) begin
            r_result <= 64'd0;
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (!div_annul) begin
            r_work <= w_work_step;
            r_cnt  <= r_cnt + 5'd1;
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!div_start) begin
            r_result <= 64'd0;
            r_ready  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_result       = r_result;
  assign div_ready        = r_ready;
  assign stallreq_for_div = w_stall & rst;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// tb_div_ctrl: scoreboard bench for the divide sequencer; expected results come
// from constants or from the simulator's own integer division.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_opdata1 = 32'd0;
  logic [31:0] div_opdata2 = 32'd0;
  logic        div_annul = 1'b0;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq_for_div;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];

  div_ctrl u_dut (
    .clk              (clk),
    .rst              (rst),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .div_opdata1      (div_opdata1),
    .div_opdata2      (div_opdata2),
    .div_annul        (div_annul),
    .div_result       (div_result),
    .div_ready        (div_ready),
    .stallreq_for_div (stallreq_for_div)
  );

  always #5 clk = ~clk;

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int lat, input string name);
    int          cycles;
    int          stalls;
    logic [63:0] want;
    @(negedge clk);
    div_start   = 1'b1;
    div_signed  = sgn;
    div_opdata1 = a;
    div_opdata2 = b;
    exp_q.push_back(expv);
    #1;
    cycles = 0;
    stalls = 0;
    while (!div_ready && cycles <= 100) begin
      if (stallreq_for_div) stalls++;
      @(negedge clk);
      cycles++;
      div_opdata1 = $urandom;
      div_opdata2 = $urandom;
    end
    total++;
    if (cycles !== lat) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cycles, lat);
    end
    total++;
    if (stalls !== lat) begin
      bad++;
      $display("FAIL %s stall_count: got %0d, expected %0d", name, stalls, lat);
    end
    want = 64'd0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got result with no expected entry, expected one queued", name);
    end else begin
      want = exp_q.pop_front();
      if (div_result !== want) begin
        bad++;
        $display("FAIL %s result: got %h, expected %h", name, div_result, want);
      end
    end
    total++;
    if (stallreq_for_div !== 1'b0) begin
      bad++;
      $display("FAIL %s stall_in_end: got %b, expected 0", name, stallreq_for_div);
    end
    @(negedge clk);
    total++;
    if (div_ready !== 1'b1 || div_result !== want) begin
      bad++;
      $display("FAIL %s hold: got ready=%b result=%h, expected ready=1 result=%h",
               name, div_ready, div_result, want);
    end
    div_start = 1'b0;
    @(negedge clk);
    total++;
    if (div_ready !== 1'b0 || div_result !== 64'd0) begin
      bad++;
      $display("FAIL %s release: got ready=%b result=%h, expected ready=0 result=0",
               name, div_ready, div_result);
    end
  endtask

  task automatic test_reset();
    div_start = 1'b1;
    #12;
    total++;
    if (div_ready !== 1'b0 || div_result !== 64'd0 || stallreq_for_div !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b result=%h stall=%b, expected all 0",
               div_ready, div_result, stallreq_for_div);
    end
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (stallreq_for_div !== 1'b0 || div_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got stall=%b ready=%b, expected 0 0", stallreq_for_div, div_ready);
    end
  endtask

  task automatic test_divu();
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, "divu_max_1");
  endtask

  task automatic test_signed();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, "div_min_m1");
  endtask

  task automatic test_divzero();
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, "divu_5_0");
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 64'd0, 2, "div_neg_0");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    int          sa;
    int          sb;
    logic [63:0] expv;
    for (int k = 0; k < 8; k++) begin
      a   = $urandom;
      b   = (k < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      sgn = k[0];
      if (b == 32'd0) b = 32'd3;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      if (sgn) begin
        sa   = a;
        sb   = b;
        expv = {32'(sa % sb), 32'(sa / sb)};
      end else begin
        expv = {a % b, a / b};
      end
      run_div(sgn, a, b, expv, 33, "random");
    end
  endtask

  task automatic test_annul();
    logic seen;
    @(negedge clk);
    div_start   = 1'b1;
    div_signed  = 1'b0;
    div_opdata1 = 32'd100;
    div_opdata2 = 32'd7;
    repeat (10) @(negedge clk);
    div_annul = 1'b1;
    div_start = 1'b0;
    #1;
    total++;
    if (stallreq_for_div !== 1'b0) begin
      bad++;
      $display("FAIL annul_stall: got %b, expected 0", stallreq_for_div);
    end
    @(negedge clk);
    div_annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (div_ready) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL annul_ready: got ready rising, expected no ready");
    end
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "after_annul_9_3");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    div_start   = 1'b1;
    div_signed  = 1'b0;
    div_opdata1 = 32'd100;
    div_opdata2 = 32'd7;
    repeat (21) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (div_ready !== 1'b0 || div_result !== 64'd0 || stallreq_for_div !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got ready=%b result=%h stall=%b, expected all 0",
               div_ready, div_result, stallreq_for_div);
    end
    div_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "after_reset_100_7");
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_divzero();
    test_random();
    test_annul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
